// File: rtl/concat_pkg.sv
// ============================================================================
// Module   : concat_pkg
// Purpose  : Shared widths, fill-state encoding and keep-mask helper for the
//            8<->32 activation width converters.
// Contents : BYTE_W, WORD_W, LANES
//            fill_t          - byte count already held in the assembly lanes
//            keep_from_fill  - lane-valid mask for a word closed at a fill
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package concat_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 32;
   localparam int LANES  = 4;

   // Number of bytes already parked in the assembly lanes.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2,
      THREE = 2'd3
   } fill_t;

   // Mask of the lanes that carry real data when the word is closed by a byte
   // arriving at lane `fill`: lanes 0..fill are valid. One extra bit of
   // headroom lets fill==3 produce 4'b1111 without overflowing the shift.
   function automatic logic [LANES-1:0] keep_from_fill(input logic [1:0] fill);
      logic [LANES:0] span;
      span = ({{LANES{1'b0}}, 1'b1} << (3'(fill) + 3'd1)) - {{LANES{1'b0}}, 1'b1};
      return span[LANES-1:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/concat_8to32.sv
// ============================================================================
// Module   : concat_8to32
// Purpose  : Packs four consecutive 8-bit activations into one 32-bit word,
//            first byte in [7:0]. s_last closes a packet early; the partial
//            word is padded with PAD_VALUE and flagged through m_keep.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            s_data/s_valid/s_last/s_ready - byte input stream
//            m_data/m_keep/m_last/m_valid/m_ready - word output stream
// Params   : PAD_VALUE         - byte placed in unused lanes of a partial word
//            RE_CHANNEL_IN_NUM - channels per pixel (informational only)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module concat_8to32
   import concat_pkg::*;
#(
   parameter logic [BYTE_W-1:0] PAD_VALUE         = 8'h00,
   parameter int                RE_CHANNEL_IN_NUM = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BYTE_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              s_last,
   output logic [WORD_W-1:0] m_data,
   output logic [LANES-1:0]  m_keep,
   output logic              m_last,
   output logic              m_valid,
   input  logic              m_ready
);

   // The channel count only sizes packets outside this block; the guard
   // below is never elaborated for a sensible value.
   if (RE_CHANNEL_IN_NUM < 1) begin : g_channel_guard
      localparam int BAD_CHANNEL_COUNT = RE_CHANNEL_IN_NUM;
   end

   fill_t             fill_q;
   fill_t             fill_d;
   logic [BYTE_W-1:0] lane_q [LANES];
   logic              accept;
   logic              take;
   logic              complete;
   logic [WORD_W-1:0] word_d;

   // Ready depends only on the output register, never on s_valid/s_last.
   assign s_ready  = !m_valid || m_ready;
   assign accept   = s_valid && s_ready;
   assign take     = m_valid && m_ready;
   assign complete = accept && ((fill_q == THREE) || s_last);

   // ------------------------------------------------------------------
   // Fill state machine
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_q <= EMPTY;
      end else begin
         fill_q <= fill_d;
      end
   end

   always_comb begin
      fill_d = fill_q;
      if (accept) begin
         if (complete) begin
            fill_d = EMPTY;
         end else begin
            case (fill_q)
               EMPTY:   fill_d = ONE;
               ONE:     fill_d = TWO;
               TWO:     fill_d = THREE;
               default: fill_d = EMPTY;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // Assembly lanes. The byte that completes a word goes straight into the
   // output register, so only non-completing bytes are parked here; lane 3
   // is therefore never written but keeps the array indexable by fill.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LANES; i++) begin
            lane_q[i] <= '0;
         end
      end else if (accept && !complete) begin
         lane_q[fill_q] <= s_data;
      end
   end

   // Word as it would look if closed by the current byte: parked lanes
   // below fill, the live byte at fill, padding above.
   always_comb begin
      word_d = {LANES{PAD_VALUE}};
      for (int i = 0; i < LANES; i++) begin
         if (i < int'(fill_q)) begin
            word_d[i*BYTE_W +: BYTE_W] = lane_q[i];
         end else if (i == int'(fill_q)) begin
            word_d[i*BYTE_W +: BYTE_W] = s_data;
         end
      end
   end

   // ------------------------------------------------------------------
   // Output register. Kept self-contained so it can be swapped for a
   // 2-entry skid buffer if the m_ready -> s_ready path gets too long.
   // A completion in the same cycle as a take simply overwrites the word.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data  <= '0;
         m_keep  <= '0;
         m_last  <= 1'b0;
         m_valid <= 1'b0;
      end else if (complete) begin
         m_data  <= word_d;
         m_keep  <= keep_from_fill(fill_q);
         m_last  <= s_last;
         m_valid <= 1'b1;
      end else if (take) begin
         m_valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: doc/concat_8to32.md
# concat_8to32

Byte-to-word packer for the activation write-back path. It accepts the stream of 8-bit saturated activations leaving the 32→8 concat/clamp stage and packs four consecutive bytes into one 32-bit word for the feature-map write buffer. This is the inverse width conversion of that stage. A `s_last` flag closes a row or packet early, flushing a partial word with padded lanes and a byte-enable mask.

## Interface

Parameters:
- `PAD_VALUE`, default 8'h00: byte written into unused lanes of a flushed partial word.
- `RE_CHANNEL_IN_NUM`, default 8: channel count per pixel. Informational only; used by the bench for packet sizing and carries no RTL dependency.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `s_data`, input, 8: activation byte.
- `s_valid`, input, 1: `s_data` and `s_last` are valid.
- `s_ready`, output, 1: block accepts a byte this cycle.
- `s_last`, input, 1: the accepted byte is the final byte of a packet.
- `m_data`, output, 32: packed word. The first byte of a group goes in `[7:0]`, then `[15:8]`, `[23:16]`, `[31:24]`.
- `m_keep`, output, 4: per-lane valid mask. Bit i covers `m_data[8i+7:8i]`.
- `m_last`, output, 1: word carries the final byte of a packet.
- `m_valid`, output, 1: output word valid.
- `m_ready`, input, 1: downstream accepts the word.

## Operation

- A byte is accepted when `s_valid & s_ready`. A word is taken when `m_valid & m_ready`.
- `s_ready = !m_valid | m_ready`. This is a combinational path from `m_ready`. The ready path carries no `s_valid` or `s_last` term.
- Fill counter `fill[1:0]` (0..3) serves as the state: EMPTY(0), ONE(1), TWO(2), THREE(3).
  - An accepted byte is written to lane `fill` of the assembly register.
  - With `fill<3` and `!s_last`, the counter moves to `fill+1`.
  - An accepted byte with `fill==3` or `s_last==1` completes the word.
    - The assembly lanes plus the current byte load into the output register.
    - Lanes above `fill` are set to `PAD_VALUE`.
    - `m_keep` becomes `(4'b0001 << (fill+1)) - 1`, so `s_last` at fill 0 gives 4'b0001 and at fill 3 gives 4'b1111.
    - `m_last` becomes `s_last`.
    - `m_valid` becomes 1 and `fill` returns to 0.
- The output register holds `m_data`, `m_keep` and `m_last` stable while `m_valid & !m_ready`.
- A word taken with no new completion in the same cycle clears `m_valid` and leaves `m_data` unchanged.
- In a cycle with both a word taken and a new completion, the new word replaces the old one and `m_valid` stays 1. No bubble is inserted.
- Data values pass through unmodified. There is no arithmetic or saturation; that is the upstream stage's job.
- When `s_last` arrives on the 4th byte, the result is a full word with `m_last=1` and no extra empty word.
- An empty packet is impossible: `s_last` always comes with a byte.

## Timing

- Reset values: `m_valid=0`, `m_data=32'h0`, `m_keep=4'h0`, `m_last=0`, `fill=0`, assembly register 0. `s_ready` reads 1 during reset because `m_valid` is 0.
- Latency: the completed word is visible on `m_*` the cycle after the completing byte is accepted.
- Throughput: one byte per cycle sustained while `m_ready` is held high.
- Reset asserted mid-group discards the partial word and any held output word. After release the next byte goes to lane 0.
- Backpressure: `m_ready=0` with `m_valid=1` drops `s_ready` immediately. No byte is accepted or lost, and `fill` and the assembly lanes hold.

## Structure

- Shared package `concat_pkg`:
  - `BYTE_W=8`, `WORD_W=32`, `LANES=4`.
  - Keep-mask function `keep_from_fill(fill)`, shared with the 32→8 stage's bench.
- Single module; no sub-module needed.
- The output register is written as one clearly separated register block so it can later become a 2-entry skid if timing on `m_ready→s_ready` fails.

## Test plan

- **Full group:** stream 8'h11, 22, 33, 44 with `m_ready=1` → one word `m_data=32'h44332211`, `m_keep=4'hF`, `m_last=0`, one cycle after the 4th byte.
- **Partial flush:** bytes 8'hAA, BB with `s_last` on BB, `PAD_VALUE=8'h00` → `m_data=32'h0000BBAA`, `m_keep=4'b0011`, `m_last=1`. The next byte then lands in lane 0.
- **Last on lane 3:** 8 bytes 01..08 with `s_last` on 08 → exactly 2 words, 32'h04030201 and 32'h08070605. The second word has `m_last=1` and `keep=4'hF`. No third word appears.
- **Backpressure:** hold `m_ready=0` for 6 cycles with a word pending and `s_valid=1` → `s_ready=0`, `m_*` stable. On release the queued bytes are packed in order with none dropped or duplicated.
- **Back-to-back:** `m_ready=1` and continuous `s_valid` for 64 bytes → 16 words on consecutive 4-cycle boundaries, `s_ready` never low.
- **Reset mid-group:** assert `rst_n=0` after 2 bytes, then send 4 bytes 8'hC0..C3 → `m_valid=0` during reset, then a single word 32'hC3C2C1C0.
